// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Brief   : Shared types and defaults for the UART transmit FIFO path.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS_DEFAULT  = 8;
  localparam int DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    SEND  = 2'd2
  } uart_tx_fifo_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_sync_fifo                                                   |
// | Brief   : Generic single-clock circular FIFO with wrap-bit pointers.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_sync_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_BITS-1:0]  wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  flush_i,
  output logic [DATA_BITS-1:0]  rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]  rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 w_full, w_empty, w_wr_ok, w_rd_ok;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
  // Writes look only at the registered full flag; a same-cycle pop does not free a slot.
  assign w_wr_ok = wr_en_i && !w_full && !flush_i;
  assign w_rd_ok = rd_en_i && !w_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = wr_en_i && w_full && !flush_i;
    if (w_wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else if (w_rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_ok) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o  = w_empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_fifo                                                     |
// | Brief   : FIFO feeding uart_tx one word per frame via its ready/busy/done  |
// |           handshake. Define UART_TX_FIFO_FLUSH_EN to add the flush_in port.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  sysclk_in,
  input  logic                  nrst_in,
  input  logic                  wr_en_in,
  input  logic [DATA_BITS-1:0]  wr_data_in,
  output logic                  full_out,
  output logic                  empty_out,
  output logic [DEPTH_LOG2:0]   level_out,
  output logic                  overflow_out,
  output logic [DATA_BITS-1:0]  tx_data_out,
  output logic                  data_rdy_out,
  input  logic                  tx_busy_in,
  input  logic                  tx_done_in
`ifdef UART_TX_FIFO_FLUSH_EN
  ,
  input  logic                  flush_in
`endif
);

  uart_tx_fifo_state_t state_q;
  logic                data_rdy_q;
  logic                busy_q;
  logic                w_busy_rise;
  logic                w_pop;
  logic                w_flush;
  logic                w_empty;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign w_flush = flush_in;
`else
  assign w_flush = 1'b0;
`endif

  // uart_tx raising busy is the acknowledgement that it latched the offered word.
  assign w_busy_rise = tx_busy_in && !busy_q;
  assign w_pop       = (state_q == OFFER) && w_busy_rise;

  uart_sync_fifo #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i      (sysclk_in),
    .nrst_i     (nrst_in),
    .wr_en_i    (wr_en_in),
    .wr_data_i  (wr_data_in),
    .rd_en_i    (w_pop),
    .flush_i    (w_flush),
    .rd_data_o  (tx_data_out),
    .full_o     (full_out),
    .empty_o    (w_empty),
    .level_o    (level_out),
    .overflow_o (overflow_out)
  );

  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      state_q    <= IDLE;
      data_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= tx_busy_in;
      case (state_q)
        IDLE: begin
          if (!w_empty && !tx_busy_in && !w_flush) begin
            state_q    <= OFFER;
            data_rdy_q <= 1'b1;
          end
        end
        OFFER: begin
          if (w_busy_rise) begin
            state_q    <= SEND;
            data_rdy_q <= 1'b0;
          end else if (w_flush) begin
            state_q    <= IDLE;
            data_rdy_q <= 1'b0;
          end
        end
        SEND: begin
          if (tx_done_in) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          data_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign empty_out    = w_empty;
  assign data_rdy_out = data_rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_tx_fifo                                                  |
// | Brief   : Scoreboard bench for uart_tx_fifo with a behavioural uart_tx.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo;

  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       nrst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, ovf, data_rdy;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic       flush = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .sysclk_in    (clk),
    .nrst_in      (nrst),
    .wr_en_in     (wr_en),
    .wr_data_in   (wr_data),
    .full_out     (full),
    .empty_out    (empty),
    .level_out    (level),
    .overflow_out (ovf),
    .tx_data_out  (tx_data),
    .data_rdy_out (data_rdy),
    .tx_busy_in   (tx_busy),
    .tx_done_in   (tx_done)
`ifdef UART_TX_FIFO_FLUSH_EN
    ,
    .flush_in     (flush)
`endif
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         hold = 1'b0;
  int         cap_count = 0;
  int         ovf_count = 0;
  int         max_level = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Behavioural uart_tx: latches the offered word, stays busy for a frame, then pulses done.
  // Every latched word is checked against the scoreboard queue.
  initial begin
    int         cnt;
    logic [7:0] e;
    cnt     = 0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst !== 1'b1) begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        cnt     = 0;
      end else begin
        tx_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            tx_busy = 1'b0;
            tx_done = 1'b1;
          end
        end else if (data_rdy === 1'b1 && !tx_busy && !hold) begin
          cap_count++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame: got %0h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              bad++;
              $display("FAIL frame: got %0h expected %0h", tx_data, e);
            end
          end
          tx_busy = 1'b1;
          cnt     = FRAME;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ovf === 1'b1) ovf_count++;
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  task automatic wr_word(input logic [7:0] d, input bit expect_out);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wr_burst(input logic [7:0] start, input int n, input int n_acc);
    for (int i = 0; i < n; i++) begin
      wr_word(8'(start + i), i < n_acc);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !tx_busy && empty === 1'b1 && data_rdy === 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_caps(input int n, input int budget);
    int k;
    k = 0;
    while (cap_count < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL capture_timeout: got %0d expected %0d", cap_count, n);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap0;
    nrst    = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rdy", 32'(data_rdy), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // single word and first-word latency
    wr_word(8'hA5, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_rdy_early", 32'(data_rdy), 32'd0);
    chk("t1_txdata", 32'(tx_data), 32'hA5);
    @(negedge clk);
    chk("t1_rdy", 32'(data_rdy), 32'd1);
    wait_drain(200);
    chk("t1_level_end", 32'(level), 32'd0);
    chk("t1_empty_end", 32'(empty), 32'd1);

    // burst fills the FIFO exactly
    hold      = 1'b1;
    ovf_count = 0;
    wr_burst(8'h00, 16, 16);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
    chk("t2_head", 32'(tx_data), 32'h00);
    hold = 1'b0;
    wait_drain(16 * (FRAME + 10) + 100);
    chk("t2_ovf", 32'(ovf_count), 32'd0);

    // seventeenth write dropped
    hold      = 1'b1;
    ovf_count = 0;
    max_level = 0;
    wr_burst(8'h20, 17, 16);
    @(negedge clk);
    chk("t3_ovf_pulse", 32'(ovf_count), 32'd1);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_level", 32'(level), 32'd16);
    hold = 1'b0;
    wait_drain(16 * (FRAME + 10) + 100);
    chk("t3_max_level", 32'(max_level), 32'd16);
    chk("t3_ovf_once", 32'(ovf_count), 32'd1);

    // pointer wrap with concurrent draining
    ovf_count = 0;
    cap0      = cap_count;
    wr_burst(8'h40, 10, 10);
    wait_caps(cap0 + 6, 10 * (FRAME + 10));
    wr_burst(8'h50, 12, 12);
    wait_drain(20 * (FRAME + 10) + 100);
    chk("t4_frames", 32'(cap_count - cap0), 32'd22);
    chk("t4_ovf", 32'(ovf_count), 32'd0);

    // reset mid-frame discards the queued word
    cap0 = cap_count;
    wr_word(8'h3C, 1'b1);
    wr_word(8'hC3, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    wait_caps(cap0 + 1, 100);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_rdy", 32'(data_rdy), 32'd0);
    chk("t5_txdata", 32'(tx_data), 32'd0);
    chk("t5_full", 32'(full), 32'd0);
    nrst = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    chk("t5_frames", 32'(cap_count - cap0), 32'd1);

`ifdef UART_TX_FIFO_FLUSH_EN
    // flush during frame 1 leaves that frame intact and sends nothing more
    cap0 = cap_count;
    wr_burst(8'h60, 4, 1);
    wait_caps(cap0 + 1, 100);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    repeat (4 * FRAME) @(negedge clk);
    chk("t6_frames", 32'(cap_count - cap0), 32'd1);
    chk("t6_level_end", 32'(level), 32'd0);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
